// File: rtl/mcu_spi_pkg.sv
// Shared defaults, fill word and frame-state encoding for the MCU SPI transmit path.
package mcu_spi_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ACK_LEVEL_DEF  = 1;
  localparam int BIT_CNT_W_DEF  = $clog2(DATA_W_DEF);

  localparam logic [DATA_W_DEF-1:0] FILL_WORD = '0;

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_IDLE,
    ST_SHIFT
  } frame_state_e;

  function automatic int bit_cnt_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/mcu_spi_tx_fifo.sv
// Synchronous first-word-fall-through transmit FIFO with occupancy count.
module mcu_spi_tx_fifo
  import mcu_spi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic                            rd_en,
  output logic [DATA_W-1:0]               rd_data,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign wr_ready = (count != CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_en && !empty;
  assign rd_data  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcu_spi_tx.sv
// MCU-facing SPI mode-0 transmitter: synchronizes SCLK/CS/REQ, shifts FIFO words out MSB first.
// Optional sticky underrun flag is built only when MCU_SPI_TX_UNDERRUN_EN is defined.
//
// state       | meaning
// ST_DISARMED | after reset; waits for CS seen high so a held-low CS cannot start a frame
// ST_IDLE     | CS high, waiting for CS falling edge
// ST_SHIFT    | frame active; SCLK falling edges shift or load the next word
module mcu_spi_tx
  import mcu_spi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ACK_LEVEL  = ACK_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              mcu_sclk,
  input  logic              mcu_cs,
  input  logic              mcu_req,
  output logic              mcu_ack,
  output logic              mcu_miso,
  output logic              mcu_miso_oe,
  output logic              underrun
);

  localparam int CNT_W  = bit_cnt_w(DATA_W);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [DATA_W-1:0] FILL = DATA_W'(FILL_WORD);

  // bits [1:0] are the synchronizer, bit [2] holds the previous synchronized value
  logic [2:0]        sclk_sync;
  logic [2:0]        cs_sync;
  logic [1:0]        req_sync;
  logic              sclk_fall;
  logic              cs_fall;
  logic              cs_rise;

  frame_state_e      state_q;
  frame_state_e      state_nxt;
  logic              load;
  logic              shift;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              oe_q;
  logic              ack_q;

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_cnt;

  mcu_spi_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (src_data),
    .wr_valid (src_valid),
    .wr_ready (src_ready),
    .rd_en    (load),
    .rd_data  (fifo_data),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign sclk_fall = sclk_sync[2] && !sclk_sync[1];
  assign cs_fall   = cs_sync[2] && !cs_sync[1];
  assign cs_rise   = !cs_sync[2] && cs_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      req_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], mcu_sclk};
      cs_sync   <= {cs_sync[1:0], mcu_cs};
      req_sync  <= {req_sync[0], mcu_req};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_DISARMED;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      ST_DISARMED: if (cs_sync[1]) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (cs_fall) begin
          state_nxt = ST_SHIFT;
          load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
        end else if (sclk_fall) begin
          // last bit of the word: reload instead of shifting for gapless bursts
          if (bit_cnt == CNT_W'(DATA_W-1)) load  = 1'b1;
          else                             shift = 1'b1;
        end
      end
      default: state_nxt = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      if (load) begin
        shreg   <= fifo_empty ? FILL : fifo_data;
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (cs_rise && state_q == ST_SHIFT) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
      oe_q  <= (state_q != ST_DISARMED) && !cs_sync[1];
      ack_q <= req_sync[1] && (ack_q || (fifo_cnt >= FCNT_W'(ACK_LEVEL)));
    end
  end

  assign mcu_miso    = shreg[DATA_W-1];
  assign mcu_miso_oe = oe_q;
  assign mcu_ack     = ack_q;

`ifdef MCU_SPI_TX_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk) begin
    if (reset)                  underrun_q <= 1'b0;
    else if (load && fifo_empty) underrun_q <= 1'b1;
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_spi_tx.sv
// Randomized bench for mcu_spi_tx against a word-queue model of the MCU-visible behaviour.
module tb_mcu_spi_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          mcu_sclk;
  logic          mcu_cs;
  logic          mcu_req;
  logic          mcu_ack;
  logic          mcu_miso;
  logic          mcu_miso_oe;
  logic          underrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] model_q[$];
  logic          model_underrun = 1'b0;
  logic          underrun_en;

  mcu_spi_tx dut (
    .clk         (clk),
    .reset       (reset),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .mcu_sclk    (mcu_sclk),
    .mcu_cs      (mcu_cs),
    .mcu_req     (mcu_req),
    .mcu_ack     (mcu_ack),
    .mcu_miso    (mcu_miso),
    .mcu_miso_oe (mcu_miso_oe),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    @(negedge clk);
    if (model_q.size() == DEPTH) begin
      chk("ready_full", {31'd0, src_ready}, 32'd0);
    end else begin
      chk("ready_free", {31'd0, src_ready}, 32'd1);
      src_data  = w;
      src_valid = 1'b1;
      @(negedge clk);
      src_valid = 1'b0;
      model_q.push_back(w);
    end
  endtask

  // Mode-0 master: nbits rising edges, no trailing falling edge before CS rises.
  task automatic frame(input int nbits);
    logic [DW-1:0] exp_words[$];
    logic [DW-1:0] rx;
    logic [DW-1:0] exp_w;
    int            nw;
    int            cnt;
    nw = (nbits + DW - 1) / DW;
    for (int k = 0; k < nw; k++) begin
      if (model_q.size() > 0) exp_words.push_back(model_q.pop_front());
      else begin
        exp_words.push_back('0);
        if (underrun_en) model_underrun = 1'b1;
      end
    end
    @(negedge clk);
    mcu_cs = 1'b0;
    idle(5);
    rx = '0;
    for (int b = 0; b < nbits; b++) begin
      mcu_sclk = 1'b1;
      rx = {rx[DW-2:0], mcu_miso};
      if (b == 0) chk("miso_oe_on", {31'd0, mcu_miso_oe}, 32'd1);
      if ((b % DW == DW-1) || (b == nbits-1)) begin
        cnt   = b % DW + 1;
        exp_w = exp_words[b / DW] >> (DW - cnt);
        chk("rx_word", {16'd0, rx}, {16'd0, exp_w});
        rx = '0;
      end
      idle(5);
      if (b != nbits-1) begin
        mcu_sclk = 1'b0;
        idle(5);
      end
    end
    mcu_cs = 1'b1;
    idle(3);
    mcu_sclk = 1'b0;
    idle(4);
    chk("miso_oe_off", {31'd0, mcu_miso_oe}, 32'd0);
    chk("underrun", {31'd0, underrun}, {31'd0, model_underrun});
    chk("fifo_cnt", 32'(dut.fifo_cnt), 32'(model_q.size()));
  endtask

  initial begin
    int n;
    logic [DW-1:0] rx;
`ifdef MCU_SPI_TX_UNDERRUN_EN
    underrun_en = 1'b1;
`else
    underrun_en = 1'b0;
`endif
    reset = 1'b1; src_data = '0; src_valid = 1'b0;
    mcu_sclk = 1'b0; mcu_cs = 1'b1; mcu_req = 1'b0;
    idle(3);
    chk("rst_ack", {31'd0, mcu_ack}, 32'd0);
    chk("rst_miso", {31'd0, mcu_miso}, 32'd0);
    chk("rst_oe", {31'd0, mcu_miso_oe}, 32'd0);
    chk("rst_ready", {31'd0, src_ready}, 32'd1);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    idle(5);

    // single word
    push_word(16'hA5C3);
    frame(16);

    // three-word gapless burst
    push_word(16'h1234); push_word(16'h5678); push_word(16'h9ABC);
    frame(48);

    // empty FIFO sends fill
    frame(16);

    // aborted word is discarded
    push_word(16'h1111); push_word(16'h2222);
    frame(7);
    frame(16);

    // full FIFO blocks the fifth push
    for (int i = 0; i < 5; i++) push_word(16'(16'h0F00 + i));
    frame(64);

    // ack handshake
    @(negedge clk);
    mcu_req = 1'b1;
    idle(6);
    chk("ack_empty", {31'd0, mcu_ack}, 32'd0);
    push_word(16'hBEEF);
    n = 0;
    while (!mcu_ack && n < 8) begin @(negedge clk); n++; end
    chk("ack_rise", {31'd0, (mcu_ack && n <= 4)}, 32'd1);
    mcu_req = 1'b0;
    n = 0;
    while (mcu_ack && n < 8) begin @(negedge clk); n++; end
    chk("ack_fall", {31'd0, (!mcu_ack && n <= 3)}, 32'd1);
    frame(16);

    // reset in the middle of a frame after 5 bits
    push_word(16'hC3A5); push_word(16'h7777);
    @(negedge clk);
    mcu_cs = 1'b0;
    idle(5);
    rx = '0;
    for (int b = 0; b < 5; b++) begin
      mcu_sclk = 1'b1;
      rx = {rx[DW-2:0], mcu_miso};
      idle(5);
      mcu_sclk = 1'b0;
      idle(5);
    end
    chk("pre_rst_bits", {16'd0, rx}, 32'h18);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", {31'd0, mcu_ack}, 32'd0);
    chk("mid_rst_miso", {31'd0, mcu_miso}, 32'd0);
    chk("mid_rst_oe", {31'd0, mcu_miso_oe}, 32'd0);
    chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    chk("mid_rst_cnt", 32'(dut.fifo_cnt), 32'd0);
    reset = 1'b0;
    model_q.delete();
    model_underrun = 1'b0;
    idle(8);
    chk("post_rst_oe", {31'd0, mcu_miso_oe}, 32'd0);
    chk("post_rst_miso", {31'd0, mcu_miso}, 32'd0);
    chk("post_rst_ready", {31'd0, src_ready}, 32'd1);
    mcu_cs = 1'b1;
    idle(6);

    // randomized pushes and frame lengths
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) push_word(16'($urandom));
      frame($urandom_range(1, 48));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
